core_if_fetch: RTL and testbench
================================

Name: core_if_fetch

Overview:
Instruction-fetch front end that consumes the program counter's pc/valid outputs and drives its pc_go/stall inputs, closing the PC-to-fetch loop. It issues one outstanding instruction-memory read per PC value using a req/ack handshake. Returned instructions go into a small FIFO toward the decode stage, together with their pc and pc+4. On a branch/jump redirect (flush) it discards buffered and in-flight fetches.

Parameters:
BUF_DEPTH, 2, fetch buffer entries; power of two, >=2
PTR_W, 1, log2(BUF_DEPTH)

Ports:
clk  in  1  clock
rst  in  1  reset
pc_in  in  32  current PC from PC unit
v_pc_in  in  1  pc_in valid
pc_plus4_in  in  32  pc_in+4 from PC unit
flush  in  1  redirect from execute; PC unit loads br/j target on pc_go
pc_go  out  1  advance PC this cycle (combinational)
stall  out  1  fetch cannot accept a new PC (combinational)
imem_req  out  1  memory read request (registered)
imem_addr  out  32  read address (registered, word aligned)
imem_ack  in  1  read complete; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
id_inst  out  32  FIFO head instruction
id_pc  out  32  FIFO head pc
id_pc_plus4  out  32  FIFO head pc+4
id_valid  out  1  FIFO non-empty
id_ready  in  1  decode accepts head
fetch_misalign  out  1  sticky misaligned-PC flag

Behaviour:
- Reset: rst is synchronous, active-high, on clk. State IDLE, FIFO empty, count 0; imem_req=0, imem_addr=0, fetch_misalign=0. id_valid=0; id_* read 0 while empty. pc_go=0, stall=0.
- FSM states: IDLE, WAIT_ACK, DROP. Only one memory request is outstanding at a time.
- IDLE issue: v_pc_in & !flush & !fetch_misalign & count<BUF_DEPTH & pc_in[1:0]==0.
  - Latch pc_in into imem_addr and req_pc, and pc_plus4_in into req_pc4.
  - imem_req=1 from the next cycle; go to WAIT_ACK.
- IDLE misalign: v_pc_in & pc_in[1:0]!=0 & !flush -> fetch_misalign=1 next cycle. No request is issued. The flag clears only on flush or rst.
- WAIT_ACK: imem_req and imem_addr are held stable until imem_ack; a request is never withdrawn.
  - imem_ack & !flush: push {imem_rdata, req_pc, req_pc4}; imem_req=0 next cycle; go to IDLE.
  - imem_ack & flush: discard the data; go to IDLE.
  - !imem_ack & flush: go to DROP with imem_req still held.
- DROP: imem_req held; on imem_ack discard the data, drop imem_req, go to IDLE. A further flush in DROP has no extra effect.
- pc_go = flush | (state==WAIT_ACK & imem_ack & !flush).
- stall = (state!=IDLE) | (count==BUF_DEPTH) | fetch_misalign.
- Space guarantee: the issue check count<BUF_DEPTH guarantees a slot for the response, since pops only free space.
- Decode side:
  - pop when id_valid & id_ready & !flush.
  - Push and pop in the same cycle: count unchanged; pointers wrap modulo BUF_DEPTH.
- Flush: clears the FIFO (count=0, pointers 0) next cycle and suppresses push/pop and issue that cycle. It also clears fetch_misalign.
- Latency: PC valid in IDLE at cycle t -> imem_req at t+1. With ack at t+1: id_valid at t+2, pc_go at t+1, new PC at t+2. Peak throughput is 1 instruction per 2 cycles.
- Reset mid-operation: an outstanding request is abandoned (imem_req=0 next cycle); the memory must tolerate dropped requests after rst.

Test Plan:
- Reset then v_pc_in=1, pc_in=0x0, zero-wait ack -> imem_req at cycle 1 with addr 0x0; pc_go=1 in cycle 1; id_valid=1 at cycle 2 with id_pc=0x0, id_pc_plus4=0x4, id_inst=rdata.
- Ack delayed 3 cycles -> imem_req/imem_addr stable for all 3 cycles; stall=1 and pc_go=0 throughout; pc_go=1 only in the ack cycle.
- id_ready=0, sequential PCs 0x0, 0x4 -> FIFO holds 2 entries, stall=1, no third imem_req. Raise id_ready -> entries leave in order 0x0 then 0x4, and the next request (0x8) is issued.
- Flush while in WAIT_ACK, ack 2 cycles later -> pc_go=1 in the flush cycle; DROP entered; ack data discarded; id_valid=0; next request uses the new pc_in (e.g. 0x100).
- Flush and imem_ack in the same cycle with 1 buffered entry -> no push, FIFO empty next cycle, state IDLE, pc_go=1.
- pc_in=0x6, v_pc_in=1 -> no imem_req, fetch_misalign=1, stall=1 held; flush -> flag clears and fetch resumes.

Source files
------------

// File: rtl/core_if_fetch.sv
// Instruction-fetch front end: one outstanding imem read per PC, a small FIFO
// toward decode holding {inst, pc, pc+4}, and discard of buffered/in-flight fetches on flush.
module core_if_fetch #(
  parameter int BUF_DEPTH = 2,
  parameter int PTR_W     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        v_pc_in,
  input  logic [31:0] pc_plus4_in,
  input  logic        flush,
  output logic        pc_go,
  output logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  input  logic        id_ready,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DROP     = 2'd2
  } state_t;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(BUF_DEPTH);

  state_t state, state_nxt;

  logic issue;
  logic mis_det;
  logic push;
  logic pop;
  logic full;

  logic [31:0] req_pc;
  logic [31:0] req_pc4;

  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [31:0] buf_inst [BUF_DEPTH];
  logic [31:0] buf_pc   [BUF_DEPTH];
  logic [31:0] buf_pc4  [BUF_DEPTH];

  assign full     = (count == DEPTH_C);
  assign id_valid = (count != '0);
  assign pop      = id_valid & id_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (issue) state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (imem_ack)   state_nxt = IDLE;
        else if (flush) state_nxt = DROP;
      end
      DROP: begin
        if (imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue   = 1'b0;
    mis_det = 1'b0;
    push    = 1'b0;
    pc_go   = 1'b0;
    stall   = 1'b0;
    if (state == IDLE) begin
      issue   = v_pc_in & ~flush & ~fetch_misalign & ~full & (pc_in[1:0] == 2'b00);
      mis_det = v_pc_in & ~flush & (pc_in[1:0] != 2'b00);
    end
    push  = (state == WAIT_ACK) & imem_ack & ~flush;
    pc_go = flush | push;
    stall = (state != IDLE) | full | fetch_misalign;
  end

  // The request stays up until acked, even across a flush; the memory sees no withdrawal.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_req  <= 1'b0;
      imem_addr <= '0;
      req_pc    <= '0;
      req_pc4   <= '0;
    end else if (issue) begin
      imem_req  <= 1'b1;
      imem_addr <= pc_in;
      req_pc    <= pc_in;
      req_pc4   <= pc_plus4_in;
    end else if ((state != IDLE) && imem_ack) begin
      imem_req  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          fetch_misalign <= 1'b0;
    else if (flush)   fetch_misalign <= 1'b0;
    else if (mis_det) fetch_misalign <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue only happens with a free slot, so a push never lands on a full buffer.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[wr_ptr] <= imem_rdata;
      buf_pc[wr_ptr]   <= req_pc;
      buf_pc4[wr_ptr]  <= req_pc4;
    end
  end

  assign id_inst     = id_valid ? buf_inst[rd_ptr] : '0;
  assign id_pc       = id_valid ? buf_pc[rd_ptr]   : '0;
  assign id_pc_plus4 = id_valid ? buf_pc4[rd_ptr]  : '0;

endmodule

// File: tb/tb_core_if_fetch.sv
// Bench for core_if_fetch: directed handshake/flush/misalign scenarios, then a
// randomized closed loop with a PC unit, a variable-latency memory and a stream model.
module tb_core_if_fetch;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        v_pc_in;
  logic [31:0] pc_plus4_in;
  logic        flush;
  logic        pc_go;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        id_ready;
  logic        fetch_misalign;

  int checks = 0;
  int errors = 0;

  core_if_fetch #(.BUF_DEPTH(DEPTH), .PTR_W(1)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .v_pc_in(v_pc_in), .pc_plus4_in(pc_plus4_in),
    .flush(flush), .pc_go(pc_go), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .id_inst(id_inst), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .id_ready(id_ready),
    .fetch_misalign(fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Apply inputs for the current cycle and move to the sampling point (negedge).
  task automatic drive(input logic v, input logic [31:0] pc, input logic fl,
                       input logic ack, input logic [31:0] rd, input logic rdy);
    v_pc_in     = v;
    pc_in       = pc;
    pc_plus4_in = pc + 32'd4;
    flush       = fl;
    imem_ack    = ack;
    imem_rdata  = rd;
    id_ready    = rdy;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] model_pc, exp_pc, tgt, prev_addr, rd;
  logic        fl, a, rdy, exp_go, pop_m, dropped, mem_busy, prev_req, prev_ack;
  int          mem_cnt, occ;

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", id_valid, 1'b0);
    check("rst_idpc", id_pc, 32'h0);
    check("rst_inst", id_inst, 32'h0);
    check("rst_mis", fetch_misalign, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_go", pc_go, 1'b0);
    next_cycle();
    rst = 1'b0;

    // zero-wait fetch of 0x0
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("c0_req", imem_req, 1'b0);
    check("c0_stall", stall, 1'b0);
    next_cycle();
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 1'b0);
    check("c1_req", imem_req, 1'b1);
    check("c1_addr", imem_addr, 32'h0);
    check("c1_go", pc_go, 1'b1);
    check("c1_stall", stall, 1'b1);
    next_cycle();
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0);
    check("c2_valid", id_valid, 1'b1);
    check("c2_pc", id_pc, 32'h0);
    check("c2_pc4", id_pc_plus4, 32'h4);
    check("c2_inst", id_inst, 32'h1111_1111);
    check("c2_stall", stall, 1'b0);
    next_cycle();

    // three-cycle ack delay on 0x4
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 1'b0);
      check("dly_req", imem_req, 1'b1);
      check("dly_addr", imem_addr, 32'h4);
      check("dly_stall", stall, 1'b1);
      check("dly_go", pc_go, 1'b0);
      next_cycle();
    end
    drive(1'b1, 32'h4, 1'b0, 1'b1, 32'h2222_2222, 1'b0);
    check("dly_ack_go", pc_go, 1'b1);
    next_cycle();

    // buffer full: no third request
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b0);
      check("full_req", imem_req, 1'b0);
      check("full_stall", stall, 1'b1);
      check("full_valid", id_valid, 1'b1);
      next_cycle();
    end
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b1);
    check("drain0_pc", id_pc, 32'h0);
    next_cycle();
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 1'b1);
    check("drain1_pc", id_pc, 32'h4);
    check("drain1_inst", id_inst, 32'h2222_2222);
    check("drain1_stall", stall, 1'b0);
    next_cycle();

    // flush during WAIT_ACK on 0x8, ack arrives two cycles later
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b1);
    check("fw_req", imem_req, 1'b1);
    check("fw_addr", imem_addr, 32'h8);
    check("fw_valid", id_valid, 1'b0);
    check("fw_go", pc_go, 1'b1);
    next_cycle();
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
    check("drop_req", imem_req, 1'b1);
    check("drop_addr", imem_addr, 32'h8);
    check("drop_stall", stall, 1'b1);
    next_cycle();
    drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h3333_3333, 1'b1);
    check("drop_ack_go", pc_go, 1'b0);
    next_cycle();
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    check("drop_done_req", imem_req, 1'b0);
    check("drop_done_valid", id_valid, 1'b0);
    next_cycle();
    drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h4444_4444, 1'b0);
    check("refetch_addr", imem_addr, 32'h100);
    check("refetch_req", imem_req, 1'b1);
    next_cycle();
    drive(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 1'b0);
    check("refetch_pc", id_pc, 32'h100);
    check("refetch_inst", id_inst, 32'h4444_4444);
    next_cycle();

    // flush coincident with ack, one entry buffered
    drive(1'b1, 32'h104, 1'b1, 1'b1, 32'h5555_5555, 1'b0);
    check("fa_go", pc_go, 1'b1);
    next_cycle();
    drive(1'b0, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
    check("fa_valid", id_valid, 1'b0);
    check("fa_req", imem_req, 1'b0);
    check("fa_stall", stall, 1'b0);
    next_cycle();

    // misaligned PC
    drive(1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 1'b0);
    check("mis0_flag", fetch_misalign, 1'b0);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 1'b0);
      check("mis_flag", fetch_misalign, 1'b1);
      check("mis_stall", stall, 1'b1);
      check("mis_req", imem_req, 1'b0);
      next_cycle();
    end
    drive(1'b1, 32'h6, 1'b1, 1'b0, 32'h0, 1'b0);
    check("mis_flush_go", pc_go, 1'b1);
    next_cycle();
    drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
    check("mis_clr", fetch_misalign, 1'b0);
    check("mis_clr_stall", stall, 1'b0);
    next_cycle();
    drive(1'b1, 32'h300, 1'b0, 1'b1, 32'h6666_6666, 1'b0);
    check("resume_addr", imem_addr, 32'h300);
    check("resume_req", imem_req, 1'b1);
    next_cycle();
    drive(1'b0, 32'h304, 1'b0, 1'b0, 32'h0, 1'b1);
    check("resume_pc", id_pc, 32'h300);
    next_cycle();

    // randomized closed loop
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    next_cycle();
    rst = 1'b0;
    model_pc = 32'h1000;
    exp_pc   = 32'h1000;
    occ      = 0;
    dropped  = 1'b0;
    mem_busy = 1'b0;
    mem_cnt  = 0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      fl  = ($urandom_range(0, 19) == 0);
      tgt = $urandom & 32'h0000_fffc;
      if ($urandom_range(0, 7) == 0) tgt = tgt | 32'h2;
      rdy = ($urandom_range(0, 2) != 0);
      a   = 1'b0;
      if (imem_req) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_cnt  = $urandom_range(0, 3);
        end
        if (mem_cnt == 0) a = 1'b1;
        else mem_cnt--;
      end
      if (prev_req && !prev_ack) begin
        check("r_hold_req", imem_req, 1'b1);
        check("r_hold_addr", imem_addr, prev_addr);
      end
      if (imem_req && !prev_req) begin
        check("r_req_addr", imem_addr, model_pc);
        check("r_req_space", (occ < DEPTH), 1'b1);
      end
      rd = a ? mem_data(imem_addr) : $urandom;
      drive(1'b1, model_pc, fl, a, rd, rdy);

      exp_go = fl | (a & ~dropped);
      check("r_go", pc_go, exp_go);
      check("r_valid", id_valid, (occ != 0));
      if (fetch_misalign) check("r_mis_pc", (model_pc[1:0] != 2'b00), 1'b1);
      pop_m = (occ != 0) && rdy && !fl;
      if (pop_m) begin
        check("r_pc", id_pc, exp_pc);
        check("r_pc4", id_pc_plus4, exp_pc + 32'd4);
        check("r_inst", id_inst, mem_data(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end

      if (fl) begin
        occ    = 0;
        exp_pc = tgt;
      end else begin
        if (a && !dropped) occ++;
        if (pop_m) occ--;
      end
      if (a) dropped = 1'b0;
      else if (fl && mem_busy) dropped = 1'b1;
      if (a) mem_busy = 1'b0;
      if (exp_go) model_pc = fl ? tgt : model_pc + 32'd4;
      prev_req  = imem_req;
      prev_addr = imem_addr;
      prev_ack  = a;
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
